// File: rtl/fw_pkg.sv
// fw_pkg: shared constants for the TCP destination-port filter.
// FSM encoding, control-word values and header field locations.
package fw_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_DECIDE  = 3'd2;
   localparam logic [2:0] S_FLUSH   = 3'd3;
   localparam logic [2:0] S_PASS    = 3'd4;
   localparam logic [2:0] S_DROP    = 3'd5;

   localparam logic [7:0]  HDR_CTRL     = 8'hFF;
   localparam logic [15:0] ETHERTYPE_IP = 16'h0800;
   localparam logic [7:0]  PROTO_TCP    = 8'd6;

   localparam int ET_WORD = 1;
   localparam int ET_LSB  = 16;
   localparam int PR_WORD = 2;
   localparam int PR_LSB  = 0;
   localparam int DP_WORD = 4;
   localparam int DP_LSB  = 16;
   localparam int MAX_HDR = 4;

endpackage

// File: rtl/fw_hdr_buf.sv
// fw_hdr_buf: small holding FIFO for the first words of a packet.
// Pointers wrap; the count is one bit wider so full is its MSB.
module fw_hdr_buf #(
   parameter int WIDTH      = 72,
   parameter int DEPTH_BITS = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clr,
   input  logic                  wr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  rd,
   output logic [WIDTH-1:0]      rdata,
   output logic [DEPTH_BITS:0]   count,
   output logic                  full,
   output logic                  empty
);

   logic [WIDTH-1:0]      mem [0:(1<<DEPTH_BITS)-1];
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic                  wr_ok;
   logic                  rd_ok;

   assign full  = count[DEPTH_BITS];
   assign empty = (count == '0);
   assign wr_ok = wr && !full;
   assign rd_ok = rd && !empty;
   assign rdata = mem[rd_ptr];

   // storage write, no reset needed on the array
   always_ff @(posedge clk)
      if (wr_ok) mem[wr_ptr] <= wdata;

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (DEPTH_BITS+1)'(wr_ok)
                        - (DEPTH_BITS+1)'(rd_ok);
      end

endmodule

// File: rtl/fw_port_filter.sv
// fw_port_filter: drops TCP packets aimed at blocked_port.
// Optional drop counter output when FW_DROP_COUNT_EN is defined.
module fw_port_filter
   import fw_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int CTRL_WIDTH     = 8,
   parameter int BUF_DEPTH_BITS = 3
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] in_fifo_dout,
   input  logic                             in_fifo_empty,
   output logic                             in_fifo_rd_en,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [CTRL_WIDTH-1:0]            out_ctrl,
   output logic                             out_wr,
   input  logic                             out_rdy,
   input  logic [15:0]                      blocked_port,
   input  logic                             filter_en
`ifdef FW_DROP_COUNT_EN
   ,
   output logic [31:0]                      drop_cnt
`endif
);

   localparam int WW    = CTRL_WIDTH + DATA_WIDTH;
   localparam int DEPTH = 1 << BUF_DEPTH_BITS;
   localparam int CW    = BUF_DEPTH_BITS + 1;

   logic [2:0]            state_q;
   logic [2:0]            state_d;
   logic [CTRL_WIDTH-1:0] in_ctrl;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_hdr;
   logic                  in_eop;
   logic                  col_done;
   logic                  drop;

   logic                  buf_wr;
   logic                  buf_rd;
   logic                  buf_clr;
   logic                  buf_full;
   logic                  buf_empty;
   logic [CW-1:0]         buf_cnt;
   logic [WW-1:0]         buf_rdata;

   logic [CW-1:0]         hdr_cnt;
   logic [2:0]            dat_idx;
   logic [15:0]           etype_q;
   logic [7:0]            proto_q;
   logic [15:0]           dport_q;
   logic                  got_dp_q;
   logic                  eop_q;

   assign in_ctrl = in_fifo_dout[WW-1:DATA_WIDTH];
   assign in_data = in_fifo_dout[DATA_WIDTH-1:0];
   assign in_hdr  = (in_ctrl == CTRL_WIDTH'(HDR_CTRL));
   assign in_eop  = (in_ctrl != '0) && !in_hdr;

   assign col_done = in_eop
                  || (!in_hdr && dat_idx == 3'(DP_WORD))
                  || (buf_cnt == CW'(DEPTH-1));

   assign drop = filter_en && got_dp_q
              && (hdr_cnt < CW'(MAX_HDR))
              && (etype_q == ETHERTYPE_IP)
              && (proto_q == PROTO_TCP)
              && (dport_q == blocked_port);

   fw_hdr_buf #(
      .WIDTH      (WW),
      .DEPTH_BITS (BUF_DEPTH_BITS)
   ) u_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (buf_clr),
      .wr      (buf_wr),
      .wdata   (in_fifo_dout),
      .rd      (buf_rd),
      .rdata   (buf_rdata),
      .count   (buf_cnt),
      .full    (buf_full),
      .empty   (buf_empty)
   );

   // next state, FIFO pops and the output word mux
   always_comb begin
      state_d       = state_q;
      in_fifo_rd_en = 1'b0;
      out_wr        = 1'b0;
      out_data      = '0;
      out_ctrl      = '0;
      buf_wr        = 1'b0;
      buf_rd        = 1'b0;
      buf_clr       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!in_fifo_empty && reset_n) begin
               in_fifo_rd_en = 1'b1;
               buf_wr        = 1'b1;
               state_d       = col_done ? S_DECIDE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (!in_fifo_empty && !buf_full) begin
               in_fifo_rd_en = 1'b1;
               buf_wr        = 1'b1;
               if (col_done) state_d = S_DECIDE;
            end
         end
         S_DECIDE: begin
            if (drop) begin
               buf_clr = 1'b1;
               state_d = S_DROP;
            end else begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            out_wr = out_rdy && !buf_empty;
            buf_rd = out_wr;
            if (out_wr) {out_ctrl, out_data} = buf_rdata;
            if (buf_empty) state_d = eop_q ? S_IDLE : S_PASS;
         end
         S_PASS: begin
            out_wr        = out_rdy && !in_fifo_empty;
            in_fifo_rd_en = out_wr;
            if (out_wr) begin
               out_ctrl = in_ctrl;
               out_data = in_data;
               if (in_eop) state_d = S_IDLE;
            end
         end
         S_DROP: begin
            if (eop_q) begin
               state_d = S_IDLE;
            end else if (!in_fifo_empty) begin
               in_fifo_rd_en = 1'b1;
               if (in_eop) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state register and capture of the fields the decision needs
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q  <= S_IDLE;
         hdr_cnt  <= '0;
         dat_idx  <= '0;
         etype_q  <= '0;
         proto_q  <= '0;
         dport_q  <= '0;
         got_dp_q <= 1'b0;
         eop_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_d == S_IDLE) begin
            hdr_cnt  <= '0;
            dat_idx  <= '0;
            got_dp_q <= 1'b0;
            eop_q    <= 1'b0;
         end else if (buf_wr) begin
            if (in_hdr) begin
               hdr_cnt <= hdr_cnt + 1'b1;
            end else begin
               dat_idx <= dat_idx + 1'b1;
               if (dat_idx == 3'(ET_WORD))
                  etype_q <= in_data[ET_LSB +: 16];
               if (dat_idx == 3'(PR_WORD))
                  proto_q <= in_data[PR_LSB +: 8];
               if (dat_idx == 3'(DP_WORD)) begin
                  dport_q  <= in_data[DP_LSB +: 16];
                  got_dp_q <= 1'b1;
               end
            end
            if (in_eop) eop_q <= 1'b1;
         end
      end

`ifdef FW_DROP_COUNT_EN
   // one count per dropped packet, bumped on the way into DROP
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n)
         drop_cnt <= '0;
      else if (state_q == S_DECIDE && drop)
         drop_cnt <= drop_cnt + 32'd1;
`endif

endmodule

// File: tb/tb_fw_port_filter.sv
// tb_fw_port_filter: randomized packets against a packet-level model.
// Covers pass, drop, backpressure, short/non-IP, reset and bypass.
module tb_fw_port_filter;

   logic        clk;
   logic        reset_n;
   logic [71:0] in_fifo_dout;
   logic        in_fifo_empty;
   logic        in_fifo_rd_en;
   logic [63:0] out_data;
   logic [7:0]  out_ctrl;
   logic        out_wr;
   logic        out_rdy;
   logic [15:0] blocked_port;
   logic        filter_en;
`ifdef FW_DROP_COUNT_EN
   logic [31:0] drop_cnt;
`endif

   fw_port_filter dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_fifo_dout  (in_fifo_dout),
      .in_fifo_empty (in_fifo_empty),
      .in_fifo_rd_en (in_fifo_rd_en),
      .out_data      (out_data),
      .out_ctrl      (out_ctrl),
      .out_wr        (out_wr),
      .out_rdy       (out_rdy),
      .blocked_port  (blocked_port),
      .filter_en     (filter_en)
`ifdef FW_DROP_COUNT_EN
      ,
      .drop_cnt      (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [71:0] fifo [$];
   logic [71:0] exp_q [$];
   int          n_chk;
   int          n_pass;
   int          out_cnt;
   int          exp_drops;
   int          rdy_mode;
   bit          pop_pend;

   task automatic chk(input string name, input logic [71:0] got,
                      input logic [71:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, got, exp);
   endtask

   function automatic bit model_drop(input int h, input int nd,
                                     input logic [15:0] et,
                                     input logic [7:0] pr,
                                     input logic [15:0] dp,
                                     input logic [15:0] bp,
                                     input bit en);
      return en && (h < 4) && (nd >= 5) && (h + 5 <= 8)
          && (et == 16'h0800) && (pr == 8'd6) && (dp == bp);
   endfunction

   function automatic logic [15:0] pick_port();
      case ($urandom_range(0, 3))
         0: return 16'd22;
         1: return 16'd80;
         2: return 16'd443;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic drive();
      in_fifo_empty = (fifo.size() == 0);
      in_fifo_dout  = (fifo.size() == 0) ? 72'h0 : fifo[0];
   endtask

   task automatic tick();
      logic [71:0] tmp;
      @(negedge clk);
      if (reset_n) begin
         chk("protocol", {70'h0, in_fifo_rd_en && in_fifo_empty,
                          out_wr && !out_rdy}, 72'h0);
         if (out_wr) begin
            out_cnt++;
            chk("exp_avail", 72'(exp_q.size() != 0), 72'h1);
            if (exp_q.size() != 0) begin
               tmp = exp_q.pop_front();
               chk("out_word", {out_ctrl, out_data}, tmp);
            end
         end
      end
      pop_pend = in_fifo_rd_en;
      @(posedge clk);
      #1;
      if (pop_pend && fifo.size() != 0) tmp = fifo.pop_front();
      case (rdy_mode)
         0: out_rdy = 1'b1;
         1: out_rdy = ~out_rdy;
         default: out_rdy = ($urandom_range(0, 3) != 0);
      endcase
      drive();
   endtask

   task automatic send_pkt(input int h, input int nd,
                           input logic [15:0] et, input logic [7:0] pr,
                           input logic [15:0] dp);
      logic [71:0] w;
      bit d;
      d = model_drop(h, nd, et, pr, dp, blocked_port, filter_en);
      if (d) exp_drops++;
      for (int i = 0; i < h; i++) begin
         w = {8'hFF, $urandom, $urandom};
         fifo.push_back(w);
         if (!d) exp_q.push_back(w);
      end
      for (int i = 0; i < nd; i++) begin
         w[63:0] = {$urandom, $urandom};
         if (i == 1) w[31:16] = et;
         if (i == 2) w[7:0] = pr;
         if (i == 4) w[31:16] = dp;
         w[71:64] = (i == nd - 1) ? 8'($urandom_range(1, 254)) : 8'h00;
         fifo.push_back(w);
         if (!d) exp_q.push_back(w);
      end
      drive();
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((fifo.size() != 0 || exp_q.size() != 0) && n < 2000) begin
         tick();
         n++;
      end
      repeat (4) tick();
      chk(name, 72'(fifo.size() == 0 && exp_q.size() == 0), 72'h1);
`ifdef FW_DROP_COUNT_EN
      chk({name, "_drops"}, 72'(drop_cnt), 72'(exp_drops));
`endif
   endtask

   task automatic directed(input string name, input int h, input int nd,
                           input logic [15:0] et, input logic [7:0] pr,
                           input logic [15:0] dp, input int words);
      int base;
      base = out_cnt;
      send_pkt(h, nd, et, pr, dp);
      wait_drain(name);
      chk({name, "_count"}, 72'(out_cnt - base), 72'(words));
   endtask

   initial begin
      int n;
      int base;
      n_chk = 0; n_pass = 0; out_cnt = 0; exp_drops = 0;
      rdy_mode = 0; pop_pend = 1'b0;
      reset_n = 1'b0; out_rdy = 1'b1;
      blocked_port = 16'd22; filter_en = 1'b1;
      drive();
      repeat (3) tick();
      chk("rst_out_wr", 72'(out_wr), 72'h0);
      chk("rst_rd_en", 72'(in_fifo_rd_en), 72'h0);
      chk("rst_out_data", 72'(out_data), 72'h0);
      chk("rst_out_ctrl", 72'(out_ctrl), 72'h0);
`ifdef FW_DROP_COUNT_EN
      chk("rst_drop_cnt", 72'(drop_cnt), 72'h0);
`endif
      reset_n = 1'b1;
      tick();

      blocked_port = 16'd22;
      directed("pass80", 1, 8, 16'h0800, 8'd6, 16'd80, 9);
      blocked_port = 16'd80;
      directed("drop80", 1, 8, 16'h0800, 8'd6, 16'd80, 0);
      directed("after_drop", 1, 8, 16'h0800, 8'd6, 16'd81, 9);
      blocked_port = 16'd22;
      rdy_mode = 1;
      directed("backpress", 1, 8, 16'h0800, 8'd6, 16'd80, 9);
      rdy_mode = 0;
      blocked_port = 16'd80;
      directed("short3", 1, 3, 16'h0800, 8'd6, 16'd80, 4);
      directed("arp", 1, 8, 16'h0806, 8'd6, 16'd80, 9);
      directed("hdr4", 4, 8, 16'h0800, 8'd6, 16'd80, 12);
      directed("hdr3_drop", 3, 5, 16'h0800, 8'd6, 16'd80, 0);
      directed("one_word", 0, 1, 16'h0800, 8'd6, 16'd80, 1);
      filter_en = 1'b0;
      directed("bypass", 1, 8, 16'h0800, 8'd6, 16'd80, 9);
      filter_en = 1'b1;

      blocked_port = 16'd22;
      base = out_cnt;
      send_pkt(1, 10, 16'h0800, 8'd6, 16'd80);
      n = 0;
      while (out_cnt - base < 7 && n < 200) begin
         tick();
         n++;
      end
      chk("rst_reach_pass", 72'(out_cnt - base >= 7), 72'h1);
      reset_n = 1'b0;
      fifo.delete();
      exp_q.delete();
      exp_drops = 0;
      drive();
      #1;
      chk("midrst_out_wr", 72'(out_wr), 72'h0);
      chk("midrst_out_data", 72'(out_data), 72'h0);
      chk("midrst_out_ctrl", 72'(out_ctrl), 72'h0);
      chk("midrst_rd_en", 72'(in_fifo_rd_en), 72'h0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      directed("post_rst", 1, 8, 16'h0800, 8'd6, 16'd80, 9);

      rdy_mode = 2;
      for (int p = 0; p < 40; p++) begin
         blocked_port = pick_port();
         filter_en = ($urandom_range(0, 4) != 0);
         send_pkt($urandom_range(0, 5), $urandom_range(1, 10),
                  ($urandom_range(0, 3) != 0) ? 16'h0800 : 16'h0806,
                  ($urandom_range(0, 3) != 0) ? 8'd6 : 8'd17,
                  ($urandom_range(0, 1) != 0) ? blocked_port : pick_port());
         wait_drain("rand_pkt");
      end

      for (int b = 0; b < 3; b++) begin
         blocked_port = pick_port();
         filter_en = 1'b1;
         rdy_mode = (b == 1) ? 0 : 2;
         for (int p = 0; p < 8; p++)
            send_pkt($urandom_range(0, 4), $urandom_range(1, 9),
                     16'h0800,
                     ($urandom_range(0, 4) != 0) ? 8'd6 : 8'd17,
                     ($urandom_range(0, 1) != 0) ? blocked_port
                                                 : pick_port());
         wait_drain("b2b_batch");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
